// File: rtl/fir_ctrl_pkg.sv
// Shared definitions for the FIR tap sequencer: FSM state encoding and default timing constants.
package fir_ctrl_pkg;

  localparam int DEF_CLK_DIV = 500;
  localparam int DEF_NTAPS   = 32;
  localparam int DEF_MAC_LAT = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_MAC,
    ST_FLUSH,
    ST_DONE
  } seq_state_e;

endpackage

// File: rtl/sample_tick_gen.sv
// Sample-rate divider: free-running 0..CLK_DIV-1 counter while enabled, strobe on the last count.
module sample_tick_gen
  import fir_ctrl_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (!en) begin
      r_cnt <= '0;
    end else if (r_cnt == CNT_LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign tick = (r_cnt == CNT_LAST);

endmodule

// File: rtl/fir_tap_sequencer.sv
// Per-sample control for a time-multiplexed FIR: write the new sample, sweep all taps
// through the external MAC, drain its pipeline, then publish the result.
module fir_tap_sequencer
  import fir_ctrl_pkg::*;
#(
  parameter  int CLK_DIV = DEF_CLK_DIV,
  parameter  int NTAPS   = DEF_NTAPS,
  parameter  int MAC_LAT = DEF_MAC_LAT,
  localparam int AW      = $clog2(NTAPS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          clr_ovr,
  output logic          smp_tick,
  output logic          din_we,
  output logic [AW-1:0] wr_addr,
  output logic [AW-1:0] data_addr,
  output logic [AW-1:0] coef_addr,
  output logic          acc_clr,
  output logic          mac_en,
  output logic          dout_valid,
  output logic          busy,
  output logic          overrun
);

  if (NTAPS + MAC_LAT + 3 > CLK_DIV) begin : g_bad_div
    $fatal(1, "fir_tap_sequencer: CLK_DIV too small for NTAPS+MAC_LAT+3");
  end
  if (NTAPS < 4 || NTAPS > 256 || (NTAPS & (NTAPS - 1)) != 0) begin : g_bad_ntaps
    $fatal(1, "fir_tap_sequencer: NTAPS must be a power of two in 4..256");
  end
  if (MAC_LAT < 0 || MAC_LAT > 4) begin : g_bad_lat
    $fatal(1, "fir_tap_sequencer: MAC_LAT must be in 0..4");
  end

  localparam logic [AW-1:0] TAP_LAST = AW'(NTAPS - 1);
  localparam logic [2:0]    FL_LAST  = 3'((MAC_LAT > 0) ? MAC_LAT - 1 : 0);

  seq_state_e    r_state;
  seq_state_e    w_state_nxt;
  logic [AW-1:0] r_tap;
  logic [AW-1:0] r_wptr;
  logic [2:0]    r_fl;
  logic          r_ovr;
  logic          w_tick;

  sample_tick_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_tick (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .tick(w_tick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_tap   <= '0;
      r_fl    <= '0;
      r_wptr  <= '0;
      r_ovr   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_tap   <= (r_state == ST_MAC) ? r_tap + 1'b1 : '0;
      r_fl    <= (r_state == ST_FLUSH) ? r_fl + 1'b1 : '0;
      if (r_state == ST_DONE) begin
        r_wptr <= r_wptr + 1'b1;
      end
      // A missed tick must survive a coincident clear request.
      if (w_tick && r_state != ST_IDLE) begin
        r_ovr <= 1'b1;
      end else if (clr_ovr) begin
        r_ovr <= 1'b0;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    din_we      = 1'b0;
    mac_en      = 1'b0;
    acc_clr     = 1'b0;
    dout_valid  = 1'b0;
    data_addr   = '0;
    coef_addr   = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_tick) begin
          w_state_nxt = ST_WRITE;
        end
      end
      ST_WRITE: begin
        din_we      = 1'b1;
        w_state_nxt = ST_MAC;
      end
      ST_MAC: begin
        mac_en    = 1'b1;
        acc_clr   = (r_tap == '0);
        coef_addr = r_tap;
        data_addr = r_wptr - r_tap;
        if (r_tap == TAP_LAST) begin
          w_state_nxt = (MAC_LAT == 0) ? ST_DONE : ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (r_fl == FL_LAST) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        dout_valid  = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign smp_tick = w_tick;
  assign wr_addr  = r_wptr;
  assign busy     = (r_state != ST_IDLE);
  assign overrun  = r_ovr;

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Directed bench for fir_tap_sequencer at default parameters: table-driven tap sweep plus
// hand-written sequences for overrun, mid-sequence reset and enable drop.
module tb_fir_tap_sequencer;

  localparam int CLK_DIV = 500;
  localparam int NTAPS   = 32;
  localparam int MAC_LAT = 2;
  localparam int AW      = 5;
  localparam int SEQ_LEN = NTAPS + MAC_LAT + 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          en = 1'b0;
  logic          clr_ovr = 1'b0;
  logic          smp_tick, din_we, acc_clr, mac_en, dout_valid, busy, overrun;
  logic [AW-1:0] wr_addr, data_addr, coef_addr;

  fir_tap_sequencer #(
    .CLK_DIV(CLK_DIV),
    .NTAPS  (NTAPS),
    .MAC_LAT(MAC_LAT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .clr_ovr   (clr_ovr),
    .smp_tick  (smp_tick),
    .din_we    (din_we),
    .wr_addr   (wr_addr),
    .data_addr (data_addr),
    .coef_addr (coef_addr),
    .acc_clr   (acc_clr),
    .mac_en    (mac_en),
    .dout_valid(dout_valid),
    .busy      (busy),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int dv_cnt = 0;
  int tick_cnt = 0;
  int mac_cnt = 0;
  int wr_log[$];

  always @(negedge clk) begin
    if (dout_valid) dv_cnt <= dv_cnt + 1;
    if (smp_tick) tick_cnt <= tick_cnt + 1;
    if (mac_en) mac_cnt <= mac_cnt + 1;
    if (din_we) wr_log.push_back(int'(wr_addr));
  end

  typedef struct {
    int   off;
    logic we, mac, clr, dv, bsy;
    int   data, coef;
  } vec_t;

  vec_t tbl[11];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_tick(input string name, input int max, output int n);
    n = 0;
    do begin
      step(1);
      n++;
    end while (!smp_tick && n < max);
    if (!smp_tick) begin
      checks++;
      failures++;
      $display("FAIL %s no smp_tick within %0d cycles", name, max);
    end
  endtask

  task automatic wait_dv(input string name, input int max, output int n);
    n = 0;
    do begin
      step(1);
      n++;
    end while (!dout_valid && n < max);
    if (!dout_valid) begin
      checks++;
      failures++;
      $display("FAIL %s no dout_valid within %0d cycles", name, max);
    end
  endtask

  function automatic longint all_outs();
    return longint'({smp_tick, din_we, wr_addr, data_addr, coef_addr,
                     acc_clr, mac_en, dout_valid, busy, overrun});
  endfunction

  // Called in the tick cycle; walks offsets 1..SEQ_LEN+1 against a reference timeline.
  task automatic check_seq(input string name, input int wp);
    for (int o = 1; o <= SEQ_LEN + 1; o++) begin
      int  k, e_data, e_coef;
      logic e_we, e_mac, e_clr, e_dv, e_bsy;
      longint act, exp;
      step(1);
      k      = o - 2;
      e_we   = (o == 1);
      e_mac  = (o >= 2 && o <= NTAPS + 1);
      e_clr  = (o == 2);
      e_dv   = (o == SEQ_LEN);
      e_bsy  = (o <= SEQ_LEN);
      e_coef = e_mac ? k : 0;
      e_data = e_mac ? ((wp - k) & (NTAPS - 1)) : 0;
      act = longint'({din_we, mac_en, acc_clr, dout_valid, busy, data_addr, coef_addr});
      exp = longint'({e_we, e_mac, e_clr, e_dv, e_bsy, AW'(e_data), AW'(e_coef)});
      chk($sformatf("%s_off%0d", name, o), act, exp);
      if (o == 1) chk($sformatf("%s_wr_addr", name), wr_addr, wp);
    end
  endtask

  initial begin
    int n, cur, errs, dv0, t0, m0;

    tbl[0]  = '{1,  1, 0, 0, 0, 1, 0,  0};
    tbl[1]  = '{2,  0, 1, 1, 0, 1, 5,  0};
    tbl[2]  = '{3,  0, 1, 0, 0, 1, 4,  1};
    tbl[3]  = '{7,  0, 1, 0, 0, 1, 0,  5};
    tbl[4]  = '{8,  0, 1, 0, 0, 1, 31, 6};
    tbl[5]  = '{9,  0, 1, 0, 0, 1, 30, 7};
    tbl[6]  = '{33, 0, 1, 0, 0, 1, 6,  31};
    tbl[7]  = '{34, 0, 0, 0, 0, 1, 0,  0};
    tbl[8]  = '{35, 0, 0, 0, 0, 1, 0,  0};
    tbl[9]  = '{36, 0, 0, 0, 1, 1, 0,  0};
    tbl[10] = '{37, 0, 0, 0, 0, 0, 0,  0};

    step(3);
    chk("reset_outputs", all_outs(), 0);
    rst = 1'b1;
    step(2);
    chk("idle_outputs", all_outs(), 0);

    // en rises in this cycle; the tick is due in the CLK_DIV-th cycle with en high.
    en = 1'b1;
    wait_tick("first_tick", 1000, n);
    chk("first_tick_cycle", n + 1, CLK_DIV);
    check_seq("s0", 0);
    wait_tick("period", 1000, n);
    chk("tick_period", n + SEQ_LEN + 1, CLK_DIV);
    check_seq("s1", 1);

    for (int s = 2; s < 5; s++) begin
      wait_tick("run_tick", 1000, n);
      wait_dv("run_dv", 100, n);
    end

    wait_tick("s5_tick", 1000, n);
    m0 = mac_cnt;
    cur = 0;
    for (int i = 0; i < 11; i++) begin
      step(tbl[i].off - cur);
      cur = tbl[i].off;
      chk($sformatf("tbl_off%0d", tbl[i].off),
          longint'({din_we, mac_en, acc_clr, dout_valid, busy, data_addr, coef_addr}),
          longint'({tbl[i].we, tbl[i].mac, tbl[i].clr, tbl[i].dv, tbl[i].bsy,
                    AW'(tbl[i].data), AW'(tbl[i].coef)}));
      if (tbl[i].off == 1) chk("tbl_wr_addr", wr_addr, 5);
    end
    chk("tbl_mac_cycles", mac_cnt - m0, NTAPS);

    for (int s = 6; s < 33; s++) begin
      wait_tick("run_tick", 1000, n);
      wait_dv("run_dv", 100, n);
    end
    step(2);
    chk("wrap_dv_count", dv_cnt, 33);
    chk("wrap_log_size", wr_log.size(), 33);
    if (wr_log.size() == 33) begin
      chk("wrap_wr_addr_31", wr_log[31], 31);
      chk("wrap_wr_addr_32", wr_log[32], 0);
      errs = 0;
      for (int i = 0; i < 33; i++) if (wr_log[i] != (i % NTAPS)) errs++;
      chk("wrap_wr_addr_errs", errs, 0);
    end

    // Extra tick at tap 10 (offset 12).
    wait_tick("ovr_tick", 1000, n);
    step(12);
    chk("ovr_at_tap10", coef_addr, 10);
    force dut.w_tick = 1'b1;
    step(1);
    release dut.w_tick;
    chk("ovr_set", overrun, 1);
    chk("ovr_no_restart", longint'({mac_en, coef_addr}), longint'({1'b1, AW'(11)}));
    wait_dv("ovr_dv", 100, n);
    chk("ovr_dv_offset", n + 13, SEQ_LEN);
    step(1);
    chk("ovr_idle_after", busy, 0);
    chk("ovr_sticky", overrun, 1);
    clr_ovr = 1'b1;
    step(1);
    clr_ovr = 1'b0;
    chk("ovr_cleared", overrun, 0);

    wait_tick("ovr2_tick", 1000, n);
    step(20);
    force dut.w_tick = 1'b1;
    clr_ovr = 1'b1;
    step(1);
    release dut.w_tick;
    clr_ovr = 1'b0;
    chk("ovr_set_wins", overrun, 1);
    wait_dv("ovr2_dv", 100, n);
    step(1);
    clr_ovr = 1'b1;
    step(1);
    clr_ovr = 1'b0;

    // Reset at tap 20 (offset 22).
    wait_tick("rst_tick", 1000, n);
    step(22);
    chk("rst_at_tap20", coef_addr, 20);
    dv0 = dv_cnt;
    rst = 1'b0;
    #1;
    chk("rst_async_outputs", all_outs(), 0);
    step(3);
    rst = 1'b1;
    chk("rst_idle", busy, 0);
    step(40);
    chk("rst_no_dv", dv_cnt - dv0, 0);
    wait_tick("rst_tick2", 1000, n);
    chk("rst_first_tick_cycle", n + 40 + 1, CLK_DIV);
    step(1);
    chk("rst_wr_after", longint'({din_we, wr_addr}), longint'({1'b1, AW'(0)}));
    wait_dv("rst_dv2", 100, n);

    // Enable drop at tap 3 (offset 5).
    wait_tick("en_tick", 1000, n);
    step(5);
    en = 1'b0;
    wait_dv("en_dv", 100, n);
    chk("en_dv_offset", n + 5, SEQ_LEN);
    t0 = tick_cnt;
    step(2000);
    chk("en_no_ticks", tick_cnt - t0, 0);
    en = 1'b1;
    wait_tick("en_retick", 1000, n);
    chk("en_retick_cycle", n + 1, CLK_DIV);
    wait_dv("en_dv2", 100, n);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
